vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with horizontal and vertical
// region FSMs, producing registered sync, data-enable, coordinates and start pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       run,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Last count of each region; the FSM leaves a region after its last count
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_FRONT_LAST = HW'(H_ACTIVE + H_FP - 1);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_FRONT_LAST = VW'(V_ACTIVE + V_FP - 1);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    H_ACT   = 2'd0,
    H_FRONT = 2'd1,
    H_SYNCP = 2'd2,
    H_BACK  = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACT   = 2'd0,
    V_FRONT = 2'd1,
    V_SYNCP = 2'd2,
    V_BACK  = 2'd3
  } v_state_t;

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  h_state_t      h_state_r;
  h_state_t      h_state_nxt_s;
  v_state_t      v_state_r;
  v_state_t      v_state_nxt_s;
  logic          h_wrap_s;
  logic          v_wrap_s;
  logic          act_s;

  // Wrap detection and active-area qualifier from the current position
  always_comb begin
    h_wrap_s = (h_cnt_r == H_LAST);
    v_wrap_s = (v_cnt_r == V_LAST);
    act_s    = (h_state_r == H_ACT) && (v_state_r == V_ACT);
  end

  // Horizontal region sequencing
  always_comb begin
    h_state_nxt_s = h_state_r;
    case (h_state_r)
      H_ACT: begin
        if (h_cnt_r == H_ACT_LAST) h_state_nxt_s = H_FRONT;
        else                       h_state_nxt_s = H_ACT;
      end
      H_FRONT: begin
        if (h_cnt_r == H_FRONT_LAST) h_state_nxt_s = H_SYNCP;
        else                         h_state_nxt_s = H_FRONT;
      end
      H_SYNCP: begin
        if (h_cnt_r == H_SYNC_LAST) h_state_nxt_s = H_BACK;
        else                        h_state_nxt_s = H_SYNCP;
      end
      H_BACK: begin
        if (h_wrap_s) h_state_nxt_s = H_ACT;
        else          h_state_nxt_s = H_BACK;
      end
      default: h_state_nxt_s = H_ACT;
    endcase
  end

  // Vertical region sequencing; only moves on the last pixel of a line
  always_comb begin
    v_state_nxt_s = v_state_r;
    case (v_state_r)
      V_ACT: begin
        if (h_wrap_s && (v_cnt_r == V_ACT_LAST)) v_state_nxt_s = V_FRONT;
        else                                     v_state_nxt_s = V_ACT;
      end
      V_FRONT: begin
        if (h_wrap_s && (v_cnt_r == V_FRONT_LAST)) v_state_nxt_s = V_SYNCP;
        else                                       v_state_nxt_s = V_FRONT;
      end
      V_SYNCP: begin
        if (h_wrap_s && (v_cnt_r == V_SYNC_LAST)) v_state_nxt_s = V_BACK;
        else                                      v_state_nxt_s = V_SYNCP;
      end
      V_BACK: begin
        if (h_wrap_s && v_wrap_s) v_state_nxt_s = V_ACT;
        else                      v_state_nxt_s = V_BACK;
      end
      default: v_state_nxt_s = V_ACT;
    endcase
  end

  // Counters, FSM state and registered decode of the pre-increment position
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      h_cnt_r     <= '0;
      v_cnt_r     <= '0;
      h_state_r   <= H_ACT;
      v_state_r   <= V_ACT;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      de          <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!run) begin
      h_cnt_r     <= '0;
      v_cnt_r     <= '0;
      h_state_r   <= H_ACT;
      v_state_r   <= V_ACT;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      de          <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      if (h_wrap_s) begin
        h_cnt_r <= '0;
        if (v_wrap_s) v_cnt_r <= '0;
        else          v_cnt_r <= v_cnt_r + VW'(1);
      end else begin
        h_cnt_r <= h_cnt_r + HW'(1);
      end
      h_state_r   <= h_state_nxt_s;
      v_state_r   <= v_state_nxt_s;
      hsync       <= (h_state_r == H_SYNCP) ? SYNC_ON : ~SYNC_ON;
      vsync       <= (v_state_r == V_SYNCP) ? SYNC_ON : ~SYNC_ON;
      de          <= act_s;
      x           <= act_s ? 10'(h_cnt_r) : 10'd0;
      y           <= act_s ? 10'(v_cnt_r) : 10'd0;
      line_start  <= (h_cnt_r == '0);
      frame_start <= (h_cnt_r == '0) && (v_cnt_r == '0);
    end else begin
      // Between pixel strobes everything holds except the one-cycle pulses
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small SYNC_POL=1
// instance driven in parallel, checked against hand tables and an arithmetic model.
module tb_vga_timing_gen;

  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } outs_t;

  typedef struct {
    logic  r;
    logic  ru;
    logic  pe;
    outs_t e;
  } vec_t;

  logic clk_in = 1'b0;
  logic reset, pix_en, run;
  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  outs_t act_d, act_s;

  int n_vec = 0;
  int n_fail = 0;
  int cycle_no = 0;
  int dh, dv, sh, sv;
  outs_t ed, es;
  vec_t tbl[13];

  always #5 clk_in = ~clk_in;

  assign act_d = {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs};
  assign act_s = {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs};

  vga_timing_gen dut_d (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en), .run(run),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1)
  ) dut_s (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en), .run(run),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  function automatic outs_t mk(input logic hs, input logic vs, input logic de,
                               input int xv, input int yv, input logic ls, input logic fs);
    outs_t o;
    o.hs = hs; o.vs = vs; o.de = de; o.x = 10'(xv); o.y = 10'(yv); o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic outs_t idle(input logic pol);
    return mk(~pol, ~pol, 1'b0, 0, 0, 1'b0, 1'b0);
  endfunction

  function automatic outs_t decode(input int h, input int v, input int ha, input int hf,
                                   input int hsw, input int va, input int vf, input int vsw,
                                   input logic pol);
    outs_t o;
    o.hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
    o.vs = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
    o.de = (h < ha) && (v < va);
    o.x  = o.de ? 10'(h) : 10'd0;
    o.y  = o.de ? 10'(v) : 10'd0;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic model_edge();
    if (reset || !run) begin
      ed = idle(1'b0); es = idle(1'b1);
      dh = 0; dv = 0; sh = 0; sv = 0;
    end else if (pix_en) begin
      ed = decode(dh, dv, 640, 16, 96, 480, 10, 2, 1'b0);
      es = decode(sh, sv, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b1);
      dh++; if (dh == 800) begin dh = 0; dv++; if (dv == 525) dv = 0; end
      sh++; if (sh == S_HT) begin sh = 0; sv++; if (sv == S_VT) sv = 0; end
    end else begin
      ed.ls = 1'b0; ed.fs = 1'b0; es.ls = 1'b0; es.fs = 1'b0;
    end
  endtask

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
               name, act.hs, act.vs, act.de, act.x, act.y, act.ls, act.fs,
               exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic ru, input logic pe, input string tag);
    reset = r; run = ru; pix_en = pe;
    @(posedge clk_in); #1;
    cycle_no++;
    model_edge();
    check({tag, "/d"}, act_d, ed);
    check({tag, "/s"}, act_s, es);
  endtask

  initial begin
    int de_n, hs_n, hs_first, ls_n, ls_c0, ls_c1;
    int fs_n, vs_n, vs_first, xmax, ymax;
    reset = 1'b1; run = 1'b0; pix_en = 1'b0;
    ed = idle(1'b0); es = idle(1'b1);
    dh = 0; dv = 0; sh = 0; sv = 0;

    // Hand-computed vectors for the default instance
    tbl[0]  = '{1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0)};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1)};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1)};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0)};
    tbl[10] = '{1'b1, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0)};
    tbl[11] = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0)};

    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].r; run = tbl[i].ru; pix_en = tbl[i].pe;
      @(posedge clk_in); #1;
      cycle_no++;
      model_edge();
      check($sformatf("tbl%0d/d", i), act_d, tbl[i].e);
      check($sformatf("tbl%0d/s", i), act_s, es);
    end

    // One full default line with a strobe every 4th clock
    cyc(1'b1, 1'b0, 1'b0, "rstA");
    de_n = 0; hs_n = 0; hs_first = -1; ls_n = 0; ls_c0 = -1; ls_c1 = -1;
    for (int k = 0; k <= 800; k++) begin
      cyc(1'b0, 1'b1, 1'b1, "lineA");
      if (k < 800) begin
        if (d_de) de_n++;
        if (!d_hs) begin
          if (hs_first < 0) hs_first = k;
          hs_n++;
        end
      end
      if (d_ls) begin
        ls_n++;
        if (ls_c0 < 0) ls_c0 = cycle_no; else ls_c1 = cycle_no;
      end
      for (int g = 0; g < 3; g++) begin
        cyc(1'b0, 1'b1, 1'b0, "gapA");
        if (d_ls) ls_n++;
      end
    end
    check_int("de_pixels", de_n, 640);
    check_int("hsync_pixels", hs_n, 96);
    check_int("hsync_first", hs_first, 656);
    check_int("line_pulses", ls_n, 2);
    check_int("line_period_clk", ls_c1 - ls_c0, 3200);

    // Two full small frames plus the wrap strobe, regular strobing
    cyc(1'b1, 1'b0, 1'b0, "rstB");
    fs_n = 0; vs_n = 0; vs_first = -1; xmax = 0; ymax = 0;
    for (int k = 0; k <= 2 * S_HT * S_VT; k++) begin
      cyc(1'b0, 1'b1, 1'b1, "frameB");
      if (s_fs) fs_n++;
      if (k < 2 * S_HT * S_VT) begin
        if (s_vs) begin
          if (vs_first < 0) vs_first = k;
          vs_n++;
        end
        if (s_de && int'(s_x) > xmax) xmax = int'(s_x);
        if (s_de && int'(s_y) > ymax) ymax = int'(s_y);
      end
      if (k == S_HT * S_VT) check_int("wrap_frame_start", int'(s_fs), 1);
      cyc(1'b0, 1'b1, 1'b0, "gapB");
    end
    check_int("frame_pulses", fs_n, 3);
    check_int("vsync_strobes", vs_n, 2 * S_VS * S_HT);
    check_int("vsync_first", vs_first, (S_VA + S_VF) * S_HT);
    check_int("x_max", xmax, S_HA - 1);
    check_int("y_max", ymax, S_VA - 1);

    // Irregular gaps of 1..7 clocks between strobes
    cyc(1'b1, 1'b0, 1'b0, "rstC");
    fs_n = 0;
    for (int k = 0; k <= 2 * S_HT * S_VT; k++) begin
      int gap;
      cyc(1'b0, 1'b1, 1'b1, "irrC");
      if (s_fs) fs_n++;
      gap = int'($urandom_range(7, 1));
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b1, 1'b0, "irrgapC");
    end
    check_int("irr_frame_pulses", fs_n, 3);

    // Reset pulse mid-line, then restart from the origin
    cyc(1'b1, 1'b0, 1'b0, "rstD");
    for (int k = 0; k < 301; k++) cyc(1'b0, 1'b1, 1'b1, "runD");
    check_int("pre_reset_x", int'(d_x), 300);
    cyc(1'b1, 1'b1, 1'b1, "midrstD");
    cyc(1'b0, 1'b1, 1'b1, "restartD");
    check_int("restart_fs", int'(d_fs), 1);

    // Run dropped mid-line, then restart from the origin
    for (int k = 0; k < 37; k++) cyc(1'b0, 1'b1, 1'b1, "runE");
    cyc(1'b0, 1'b0, 1'b1, "stopE");
    cyc(1'b0, 1'b0, 1'b1, "stopE");
    cyc(1'b0, 1'b0, 1'b0, "stopE");
    check_int("stopped_de", int'(d_de), 0);
    cyc(1'b0, 1'b1, 1'b1, "restartE");
    check_int("restart_ls", int'(d_ls), 1);
    cyc(1'b0, 1'b1, 1'b0, "holdE");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
